// File: rtl/l_next_arbiter.sv
// Round-robin arbiter serializing I/D line fills onto one fixed-latency memory port.
// Optional grant counters under `L_NEXT_ARB_STATS_EN`.
module l_next_arbiter #(
    parameter int LATENCY = 4,
    parameter int CNT_W   = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_req,
    input  logic [25:0]  i_addr,
    output logic         i_ack,
    output logic         i_fill_valid,
    output logic [511:0] i_fill_data,
    input  logic         d_req,
    input  logic [25:0]  d_addr,
    output logic         d_ack,
    output logic         d_fill_valid,
    output logic [511:0] d_fill_data,
    output logic [25:0]  mem_addr,
    input  logic [511:0] mem_data,
    output logic         busy
`ifdef L_NEXT_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] i_grant_cnt,
    output logic [CNT_W-1:0] d_grant_cnt
`endif
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    logic [0:0] state;
    logic       src;
    logic       last;
    logic [7:0] cnt;
    logic       grant_i;
    logic       grant_d;

    // On a tie the side that did not win last time goes first (last: 0=I, 1=D).
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == S_IDLE) begin
            grant_i = i_req && (!d_req || last);
            grant_d = d_req && (!i_req || !last);
        end
    end

    assign busy = (state == S_ACCESS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            src          <= 1'b0;
            last         <= 1'b1;
            cnt          <= 8'd0;
            mem_addr     <= 26'd0;
            i_ack        <= 1'b0;
            d_ack        <= 1'b0;
            i_fill_valid <= 1'b0;
            d_fill_valid <= 1'b0;
            i_fill_data  <= 512'd0;
            d_fill_data  <= 512'd0;
        end else begin
            i_ack        <= grant_i;
            d_ack        <= grant_d;
            i_fill_valid <= 1'b0;
            d_fill_valid <= 1'b0;
            if (state == S_IDLE) begin
                if (grant_i || grant_d) begin
                    mem_addr <= grant_i ? i_addr : d_addr;
                    src      <= grant_d;
                    last     <= grant_d;
                    cnt      <= 8'(LATENCY - 1);
                    state    <= S_ACCESS;
                end
            end else begin
                if (cnt != 8'd0) begin
                    cnt <= cnt - 8'd1;
                end else begin
                    // Final access edge: the only point mem_data is sampled.
                    if (src) begin
                        d_fill_data  <= mem_data;
                        d_fill_valid <= 1'b1;
                    end else begin
                        i_fill_data  <= mem_data;
                        i_fill_valid <= 1'b1;
                    end
                    state <= S_IDLE;
                end
            end
        end
    end

`ifdef L_NEXT_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            i_grant_cnt <= '0;
            d_grant_cnt <= '0;
        end else begin
            if (grant_i && (i_grant_cnt != {CNT_W{1'b1}}))
                i_grant_cnt <= i_grant_cnt + 1'b1;
            if (grant_d && (d_grant_cnt != {CNT_W{1'b1}}))
                d_grant_cnt <= d_grant_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/l_next_arbiter.md
# l_next_arbiter

Arbiter and sequencer for the shared next-level memory port. It accepts line-fill requests from the instruction cache and the data cache and serializes them onto the single 26-bit line-address, 512-bit line-data memory port with round-robin fairness. It models a fixed memory access latency and returns each line to the requester that issued it. It sits between the L1 I/D miss handlers and the next-level memory model.

## Interface
Parameters:
- `LATENCY`, 4: cycles the memory port stays busy per access; legal range 1..255.
- `CNT_W`, 16: width of the grant counters; used only with `L_NEXT_ARB_STATS_EN`.

Ports:
- `clk`  in  1  the single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_req`  in  1  I-cache fill request; level, held until `i_ack`.
- `i_addr`  in  26  I-cache line address; stable while `i_req` is high.
- `i_ack`  out  1  one-cycle pulse: I request accepted.
- `i_fill_valid`  out  1  one-cycle pulse: `i_fill_data` holds the requested line.
- `i_fill_data`  out  512  returned I line.
- `d_req`, `d_addr`, `d_ack`, `d_fill_valid`, `d_fill_data`: same as the I-side ports, for the D-cache.
- `mem_addr`  out  26  line address driven to next-level memory.
- `mem_data`  in  512  line data from next-level memory; a combinational function of `mem_addr`.
- `busy`  out  1  high while an access is in flight (state ACCESS).
- `i_grant_cnt`, `d_grant_cnt`  out  CNT_W  grant counts; present only with `L_NEXT_ARB_STATS_EN`.

## Operation
- FSM states: IDLE and ACCESS. Registers: `src` (0=I, 1=D), `last` (last side granted), `cnt` (8 bits), `mem_addr`.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one request: grant that side.
- IDLE, both requests: grant the side not equal to `last`.
- Grant actions, all on the same edge:
  - latch the winner's address into `mem_addr`;
  - set `src` to the winner and `last` to the winner;
  - set `cnt = LATENCY-1`;
  - assert the winner's `ack` for the next cycle;
  - go to ACCESS.
- ACCESS: requests are ignored.
  - If `cnt != 0`, decrement `cnt`.
  - If `cnt == 0`, capture `mem_data` into the `src` side's fill_data register, pulse that side's `fill_valid` for the next cycle, and go to IDLE.
- Each side's `fill_data` holds its value until that side's next fill. The other side's `fill_data` is never modified.
- A requester must drop `req` on the edge that ends its `ack` cycle. A `req` still high after that is treated as a new request.
- `mem_addr` holds the last granted address while IDLE.
- Reset values:
  - state IDLE;
  - `last` = D, so I wins the first tie;
  - `cnt` = 0, `src` = 0;
  - `mem_addr` = 0;
  - all acks and fill_valids = 0;
  - both fill_data = 0;
  - `busy` = 0;
  - counters = 0.
- Reset during ACCESS abandons the access: no `fill_valid` is issued and the arbiter is idle on the next cycle.

## Timing
- Request sampled high in IDLE at edge T:
  - `ack` is high in cycle T+1;
  - `busy` is high in cycles T+1 through T+LATENCY;
  - `fill_valid` is high in cycle T+LATENCY+1.
- The arbiter is back in IDLE in the `fill_valid` cycle and may grant a new request on that edge. Minimum grant-to-grant spacing is LATENCY+1 cycles.
- With LATENCY=1: ack in T+1, fill_valid in T+2.
- `i_ack` and `d_ack` are never high in the same cycle. The same holds for `i_fill_valid` and `d_fill_valid`.
- `mem_data` is sampled only on the final ACCESS edge. `mem_addr` is stable for the whole ACCESS interval.

## Configuration
- `L_NEXT_ARB_STATS_EN` defined:
  - adds `i_grant_cnt` and `d_grant_cnt`;
  - each counter increments on its side's grant edge;
  - each saturates at all-ones (2^CNT_W-1) and does not wrap;
  - both clear on `reset`.
- `L_NEXT_ARB_STATS_EN` undefined: the counter ports and their logic are absent, and all other behaviour is identical.

## Test plan
- Single I request, LATENCY=4, `i_addr`=26'h0000123: `i_ack` high at T+1; `busy` high T+1..T+4; `i_fill_valid` high at T+5 with `i_fill_data` = model line for 26'h0000123. D outputs stay 0.
- Simultaneous `i_req` and `d_req` after reset, both held: I granted first, D granted in the I fill cycle (T+5), D fill at T+10. A third tie goes to I.
- Continuous D-only requests for 3 lines, LATENCY=1: grants spaced 2 cycles apart. Each `d_fill_data` matches its own address. `i_fill_data` stays 0.
- Reset asserted at T+2 of an access: no `fill_valid` follows; all outputs return to reset values next cycle. The next tie goes to I.
- `i_req` arrives during a D access: not acked until D's fill cycle, then acked one cycle later.
- With `L_NEXT_ARB_STATS_EN` and CNT_W=2: 5 I grants give `i_grant_cnt` = 3 (saturated), and `d_grant_cnt` = 0.
